// File: rtl/vwi_tx_scanner.sv
// Virtual-wire transmit scanner: synchronises and glitch-filters the async wire inputs,
// then sends one valid/ready message per chunk that differs from the far side's copy.
module vwi_tx_scanner #(
    parameter  int V_WIRES_IN    = 32,
    parameter  int CHUNK_W       = 8,
    parameter  int SYNC_STAGES   = 2,
    parameter  int STABLE_CYCLES = 4,
    localparam int NCHUNK        = V_WIRES_IN / CHUNK_W,
    localparam int IDX_W         = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
    input  logic                  d2d_sb_clk,
    input  logic                  d2d_sb_rst_b,
    input  logic                  ip_ready,
    input  logic [V_WIRES_IN-1:0] async_virt_in,
    input  logic [V_WIRES_IN-1:0] strap_default_wires_in,
    input  logic                  resend_all,
    output logic [V_WIRES_IN-1:0] async_virt_in_s,
    output logic                  vw_msg_valid,
    input  logic                  vw_msg_ready,
    output logic [IDX_W-1:0]      vw_msg_idx,
    output logic [CHUNK_W-1:0]    vw_msg_data,
    output logic                  vw_pending
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {INIT, IDLE, SEND} state_t;

    state_t                state, state_nxt;
    logic [V_WIRES_IN-1:0] sync_q [SYNC_STAGES];
    logic [V_WIRES_IN-1:0] sync_out, sync_prev, filt_q, sent_q;
    logic [CNT_W-1:0]      stab_cnt, stab_cnt_nxt;
    logic [NCHUNK-1:0]     force_q, dirty;
    logic [IDX_W-1:0]      rr_ptr, sel_idx;
    logic                  sel_found, issue, accept;

    assign sync_out        = sync_q[SYNC_STAGES-1];
    assign async_virt_in_s = filt_q;
    assign vw_msg_valid    = (state == SEND);
    assign vw_pending      = |dirty;

    // Synchroniser stage boundary
    always_ff @(posedge d2d_sb_clk or negedge d2d_sb_rst_b) begin
        if (!d2d_sb_rst_b) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            sync_prev <= '0;
        end else begin
            sync_q[0] <= async_virt_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            sync_prev <= sync_out;
        end
    end

    always_comb begin
        if (sync_out != sync_prev)
            stab_cnt_nxt = CNT_W'(1);
        else if (stab_cnt >= CNT_W'(STABLE_CYCLES))
            stab_cnt_nxt = CNT_W'(STABLE_CYCLES);
        else
            stab_cnt_nxt = stab_cnt + 1'b1;
    end

    // Filter and last-delivered shadow; both start from the straps so defaults are never sent
    always_ff @(posedge d2d_sb_clk or negedge d2d_sb_rst_b) begin
        if (!d2d_sb_rst_b) begin
            stab_cnt <= '0;
            filt_q   <= '0;
            sent_q   <= '0;
        end else if (state == INIT) begin
            stab_cnt <= '0;
            filt_q   <= strap_default_wires_in;
            sent_q   <= strap_default_wires_in;
        end else begin
            stab_cnt <= stab_cnt_nxt;
            if (stab_cnt_nxt >= CNT_W'(STABLE_CYCLES) && sync_out != filt_q)
                filt_q <= sync_out;
            if (accept)
                sent_q[int'(vw_msg_idx)*CHUNK_W +: CHUNK_W] <= vw_msg_data;
        end
    end

    always_ff @(posedge d2d_sb_clk or negedge d2d_sb_rst_b) begin
        if (!d2d_sb_rst_b)
            force_q <= '0;
        else if (resend_all)
            force_q <= '1;
        else if (accept)
            force_q[vw_msg_idx] <= 1'b0;
    end

    always_comb begin
        dirty = '0;
        for (int i = 0; i < NCHUNK; i++)
            dirty[i] = (filt_q[i*CHUNK_W +: CHUNK_W] != sent_q[i*CHUNK_W +: CHUNK_W]) | force_q[i];
    end

    // Round-robin pick: first dirty chunk at or after rr_ptr
    always_comb begin
        int j;
        j         = 0;
        sel_idx   = rr_ptr;
        sel_found = 1'b0;
        for (int k = 0; k < NCHUNK; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NCHUNK) j = j - NCHUNK;
            if (!sel_found && dirty[j]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(j);
            end
        end
    end

    always_ff @(posedge d2d_sb_clk or negedge d2d_sb_rst_b) begin
        if (!d2d_sb_rst_b) state <= INIT;
        else               state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        accept    = 1'b0;
        case (state)
            INIT: state_nxt = IDLE;
            IDLE: if (ip_ready && sel_found) begin
                issue     = 1'b1;
                state_nxt = SEND;
            end
            SEND: if (vw_msg_ready) begin
                accept    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = INIT;
        endcase
    end

    // Message stage boundary: idx/data latched on issue and held through SEND
    always_ff @(posedge d2d_sb_clk or negedge d2d_sb_rst_b) begin
        if (!d2d_sb_rst_b) begin
            vw_msg_idx  <= '0;
            vw_msg_data <= '0;
            rr_ptr      <= '0;
        end else begin
            if (issue) begin
                vw_msg_idx  <= sel_idx;
                vw_msg_data <= filt_q[int'(sel_idx)*CHUNK_W +: CHUNK_W];
            end
            if (accept)
                rr_ptr <= (vw_msg_idx == IDX_W'(NCHUNK-1)) ? '0 : vw_msg_idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_vwi_tx_scanner.sv
// Directed bench for vwi_tx_scanner at default parameters (32 wires, 4 chunks of 8).
module tb_vwi_tx_scanner;

    logic        d2d_sb_clk;
    logic        d2d_sb_rst_b;
    logic        ip_ready;
    logic [31:0] async_virt_in;
    logic [31:0] strap_default_wires_in;
    logic        resend_all;
    logic [31:0] async_virt_in_s;
    logic        vw_msg_valid;
    logic        vw_msg_ready;
    logic [1:0]  vw_msg_idx;
    logic [7:0]  vw_msg_data;
    logic        vw_pending;

    int          n_vec;
    int          n_err;
    logic [15:0] msgs[$];

    vwi_tx_scanner dut (
        .d2d_sb_clk             (d2d_sb_clk),
        .d2d_sb_rst_b           (d2d_sb_rst_b),
        .ip_ready               (ip_ready),
        .async_virt_in          (async_virt_in),
        .strap_default_wires_in (strap_default_wires_in),
        .resend_all             (resend_all),
        .async_virt_in_s        (async_virt_in_s),
        .vw_msg_valid           (vw_msg_valid),
        .vw_msg_ready           (vw_msg_ready),
        .vw_msg_idx             (vw_msg_idx),
        .vw_msg_data            (vw_msg_data),
        .vw_pending             (vw_pending)
    );

    initial d2d_sb_clk = 1'b0;
    always #5 d2d_sb_clk = ~d2d_sb_clk;

    // Record every completed handshake as {idx, data}
    always @(posedge d2d_sb_clk)
        if (d2d_sb_rst_b && vw_msg_valid && vw_msg_ready)
            msgs.push_back({6'd0, vw_msg_idx, vw_msg_data});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge d2d_sb_clk);
        #1;
    endtask

    task automatic wait_msgs(input string tag, input int n);
        for (int i = 0; i < 200 && msgs.size() < n; i++) tick();
        chk(tag, msgs.size(), n);
    endtask

    task automatic chk_msg(input string tag, input int i, input logic [15:0] exp);
        chk(tag, (i < msgs.size()) ? {16'd0, msgs[i]} : 32'hFFFF_FFFF, {16'd0, exp});
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        d2d_sb_rst_b           = 1'b0;
        ip_ready               = 1'b1;
        vw_msg_ready           = 1'b1;
        resend_all             = 1'b0;
        strap_default_wires_in = 32'h0000_00A5;
        async_virt_in          = 32'h0000_00A5;
        #1;
        chk("rst_valid",   vw_msg_valid,    0);
        chk("rst_pending", vw_pending,      0);
        chk("rst_s",       async_virt_in_s, 0);
        chk("rst_idx",     vw_msg_idx,      0);
        chk("rst_data",    vw_msg_data,     0);
        repeat (3) tick();
        d2d_sb_rst_b = 1'b1;

        // Defaults, no traffic
        tick();
        chk("init_s",       async_virt_in_s, 32'h0000_00A5);
        chk("init_pending", vw_pending,      0);
        repeat (20) tick();
        chk("idle_nomsg",   msgs.size(),     0);
        chk("idle_pending", vw_pending,      0);

        // Filter latency: flip bit 9 just after edge 0
        async_virt_in = 32'h0000_02A5;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (e == 5) chk("lat_e5_s",     async_virt_in_s, 32'h0000_00A5);
            if (e == 6) chk("lat_e6_s",     async_virt_in_s, 32'h0000_02A5);
            if (e == 6) chk("lat_e6_valid", vw_msg_valid,    0);
            if (e == 7) chk("lat_e7_valid", vw_msg_valid,    1);
            if (e == 7) chk("lat_e7_idx",   vw_msg_idx,      1);
            if (e == 7) chk("lat_e7_data",  vw_msg_data,     8'h02);
            if (e == 7) chk("lat_e7_pend",  vw_pending,      1);
            if (e == 8) chk("lat_e8_valid", vw_msg_valid,    0);
            if (e == 8) chk("lat_e8_pend",  vw_pending,      0);
        end
        chk("lat_cnt", msgs.size(), 1);
        chk_msg("lat_msg", 0, 16'h0102);

        // Glitch reject: 3-cycle pulse on bit 0
        msgs.delete();
        async_virt_in = 32'h0000_02A4;
        repeat (3) tick();
        async_virt_in = 32'h0000_02A5;
        repeat (15) tick();
        chk("glitch_s",     async_virt_in_s, 32'h0000_02A5);
        chk("glitch_nomsg", msgs.size(),     0);
        chk("glitch_pend",  vw_pending,      0);

        // Round-robin: move rr_ptr to 3 via a chunk-2 message, then change chunks 0, 2, 3
        async_virt_in = 32'h0001_02A5;
        wait_msgs("rr_pre_cnt", 1);
        chk_msg("rr_pre_msg", 0, 16'h0201);
        repeat (3) tick();
        msgs.delete();
        async_virt_in = 32'h5502_02A4;
        wait_msgs("rr_cnt", 3);
        chk_msg("rr_msg0", 0, 16'h0355);
        chk_msg("rr_msg1", 1, 16'h00A4);
        chk_msg("rr_msg2", 2, 16'h0202);
        repeat (3) tick();
        msgs.delete();
        async_virt_in = 32'hAA02_02A6;
        wait_msgs("rr_wrap_cnt", 2);
        chk_msg("rr_wrap_msg0", 0, 16'h03AA);
        chk_msg("rr_wrap_msg1", 1, 16'h00A6);
        repeat (3) tick();

        // Backpressure with a late change to the chunk in flight
        msgs.delete();
        vw_msg_ready  = 1'b0;
        async_virt_in = 32'hAA02_33A6;
        for (int i = 0; i < 50 && !vw_msg_valid; i++) tick();
        chk("bp_valid", vw_msg_valid, 1);
        chk("bp_idx",   vw_msg_idx,   1);
        chk("bp_data",  vw_msg_data,  8'h33);
        async_virt_in = 32'hAA02_44A6;
        ip_ready      = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold_valid", vw_msg_valid, 1);
            chk("bp_hold_idx",   vw_msg_idx,   1);
            chk("bp_hold_data",  vw_msg_data,  8'h33);
        end
        chk("bp_late_s", async_virt_in_s, 32'hAA02_44A6);
        ip_ready     = 1'b1;
        vw_msg_ready = 1'b1;
        wait_msgs("bp_cnt", 2);
        chk_msg("bp_msg0", 0, 16'h0133);
        chk_msg("bp_msg1", 1, 16'h0144);
        repeat (3) tick();
        chk("bp_pend", vw_pending, 0);

        // resend_all with rr_ptr first brought back to 0
        msgs.delete();
        async_virt_in = 32'hBB02_44A6;
        wait_msgs("rs_pre_cnt", 1);
        chk_msg("rs_pre_msg", 0, 16'h03BB);
        repeat (3) tick();
        msgs.delete();
        resend_all = 1'b1;
        tick();
        resend_all = 1'b0;
        wait_msgs("rs_cnt", 4);
        chk_msg("rs_msg0", 0, 16'h00A6);
        chk_msg("rs_msg1", 1, 16'h0144);
        chk_msg("rs_msg2", 2, 16'h0202);
        chk_msg("rs_msg3", 3, 16'h03BB);
        repeat (10) tick();
        chk("rs_exact", msgs.size(), 4);
        chk("rs_pend",  vw_pending,  0);

        // Reset during the second message of another resend
        msgs.delete();
        resend_all = 1'b1;
        tick();
        resend_all = 1'b0;
        for (int i = 0; i < 50 && !(msgs.size() == 1 && vw_msg_valid); i++) tick();
        chk("mr_2nd_valid", {30'd0, msgs.size() == 1, vw_msg_valid}, 32'd3);
        chk("mr_2nd_idx",   vw_msg_idx, 1);
        d2d_sb_rst_b = 1'b0;
        #1;
        chk("mr_valid_drop", vw_msg_valid, 0);
        chk("mr_pend_drop",  vw_pending,   0);
        async_virt_in = 32'h0000_00A5;
        repeat (3) tick();
        d2d_sb_rst_b = 1'b1;
        msgs.delete();
        repeat (30) tick();
        chk("mr_nomsg", msgs.size(),     0);
        chk("mr_pend",  vw_pending,      0);
        chk("mr_s",     async_virt_in_s, 32'h0000_00A5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vwi_tx_scanner.md
Name: vwi_tx_scanner

Overview:
- Sits directly upstream of the sideband virtual-wire message path, in the d2d_sb_clk domain.
- Synchronises and glitch-filters the asynchronous virtual-wire inputs (async_virt_in) and exports the filtered vector (async_virt_in_s).
- Tracks which CHUNK_W-bit chunks differ from the last value delivered to the far side.
- Issues one valid/ready message per dirty chunk, scanning chunks round-robin.
- The last-delivered shadow is initialised from the strap defaults, so wires already at their default value are not sent after reset.

Parameters:
- V_WIRES_IN, 32: number of virtual wires. Must be a multiple of CHUNK_W.
- CHUNK_W, 8: wires carried per message.
- SYNC_STAGES, 2: synchroniser depth. Must be at least 2.
- STABLE_CYCLES, 4: consecutive stable cycles required before a new value is accepted. Must be at least 1.
- NCHUNK, V_WIRES_IN/CHUNK_W: derived parameter, not overridable.
- IDX_W, max(1,clog2(NCHUNK)): derived parameter.

Ports:
- d2d_sb_clk  in  1  sole clock.
- d2d_sb_rst_b  in  1  asynchronous, active-low reset.
- ip_ready  in  1  message issue is permitted only while high.
- async_virt_in  in  V_WIRES_IN  asynchronous wire inputs.
- strap_default_wires_in  in  V_WIRES_IN  reset default, treated as quasi-static.
- resend_all  in  1  single-cycle pulse; marks every chunk dirty.
- async_virt_in_s  out  V_WIRES_IN  filtered, synchronised wire vector (filt_q).
- vw_msg_valid  out  1  message request.
- vw_msg_ready  in  1  downstream accept.
- vw_msg_idx  out  IDX_W  chunk index.
- vw_msg_data  out  CHUNK_W  chunk value.
- vw_pending  out  1  OR of all dirty bits.

Behaviour:
- Reset, asynchronous while d2d_sb_rst_b is low:
  - All flops are cleared: sync chain, sync_prev, stab_cnt, filt_q, sent_q, force, rr_ptr, message registers.
  - FSM is in INIT.
  - All outputs are 0.
  - Assertion of reset mid-message drops vw_msg_valid immediately; the handshake is abandoned.
- INIT, the first edge after reset release:
  - filt_q and sent_q are loaded with strap_default_wires_in; stab_cnt is set to 0.
  - FSM moves to IDLE.
  - The sync chain runs during INIT.
  - A resend_all pulse in INIT is honoured.
- Synchroniser: SYNC_STAGES flops; sync_out is the last stage.
- Filter:
  - stab_cnt is set to 1 when sync_out != sync_prev; otherwise it increments, saturating at STABLE_CYCLES.
  - filt_q takes sync_out on any edge where the next stab_cnt value is >= STABLE_CYCLES and sync_out != filt_q.
  - Filter operates on the whole vector; there is no per-bit filtering.
  - Latency from an input change to async_virt_in_s is SYNC_STAGES+STABLE_CYCLES edges.
  - Pulses shorter than STABLE_CYCLES cycles at sync_out never reach filt_q.
- Dirty detection:
  - dirty[i] = (filt_q chunk i != sent_q chunk i) | force[i].
  - resend_all sets force to all ones on the next edge.
  - vw_pending = |dirty, combinational from registers.
- FSM IDLE:
  - Condition to issue: ip_ready=1, |dirty, and not INIT.
  - Selection: the first dirty index at or after rr_ptr, wrapping modulo NCHUNK.
  - On issue, the index and the filt_q chunk are latched into vw_msg_idx and vw_msg_data, vw_msg_valid goes to 1 on that edge, and the FSM moves to SEND.
- FSM SEND:
  - vw_msg_valid, idx and data are held stable until vw_msg_ready=1.
  - valid is never retracted: an ip_ready drop does not deassert it.
  - On valid&ready:
    - sent_q chunk idx takes the latched data.
    - force[idx] is cleared, unless resend_all is high on the same edge, in which case force stays all ones.
    - rr_ptr becomes idx+1 modulo NCHUNK, wrapping from NCHUNK-1 to 0.
    - valid goes to 0 and the FSM returns to IDLE.
  - Peak rate is one message every 2 cycles.
- A filt_q change to a chunk while its message is in SEND leaves that chunk dirty after completion, because sent_q holds the latched data. It is therefore re-sent later; no update is lost.
- ready=1 while valid=0 has no effect.

Test Plan:
- Defaults, no traffic.
  - Stimulus: strap=0x0000_00A5, async_virt_in=0x0000_00A5, reset released.
  - Required: vw_pending=0, no valid ever asserted, async_virt_in_s=0x0000_00A5 after INIT.
- Filter latency.
  - Stimulus: flip async bit 9 at edge 0 (defaults SYNC_STAGES=2, STABLE_CYCLES=4).
  - Required: async_virt_in_s[9] changes at edge 6; valid rises at edge 7 with idx=1 and data carrying bit 1 set. With ready tied high, sent_q updates and vw_pending=0 afterwards.
- Glitch reject.
  - Stimulus: 3-cycle pulse on bit 0.
  - Required: async_virt_in_s is unchanged and no message is issued.
- Round-robin and wrap.
  - Stimulus: chunks 0, 2 and 3 changed simultaneously with rr_ptr=3.
  - Required: message order is idx 3, 0, 2, and rr_ptr ends at 3.
- Backpressure and late change.
  - Stimulus: hold ready=0 for 10 cycles during SEND of chunk 1 while chunk 1's input changes again.
  - Required: idx and data are stable throughout; after acceptance a second message for chunk 1 carries the new value.
- resend_all plus reset mid-operation.
  - Stimulus: resend_all pulse with ip_ready=1 and ready high.
  - Required: exactly 4 messages, idx 0..3.
  - Stimulus: assert reset during the second message.
  - Required: valid drops immediately, and after release no messages are sent if the inputs equal the strap values.
